dmem_uart: RTL

//  Memory-mapped UART responder on the core data-memory bus (dmem_*): 8N1 transmitter

---
 rtl/dmem_uart.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_uart.sv
// rtl/dmem_uart.sv - memory-mapped 8N1 UART responder on the core data-memory bus
module dmem_uart #(
  parameter int TX_DEPTH        = 8,
  parameter int DEFAULT_DIVISOR = 434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] dmem_address,
  input  logic        dmem_enable,
  input  logic [31:0] dmem_write_data,
  input  logic        dmem_write_enable,
  input  logic [2:0]  dmem_write_mode,
  input  logic        dmem_read_enable,
  input  logic [2:0]  dmem_read_mode,
  output logic [31:0] dmem_read_data,
  output logic        dmem_wait,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int          AW      = $clog2(TX_DEPTH);
  localparam logic [AW:0] DEPTH_P = TX_DEPTH[AW:0];
  localparam logic [15:0] DEF_DIV = 16'(DEFAULT_DIVISOR);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [1:0]  sel;
  logic        wr_req, rd_req, push, rx_pop;
  logic [AW:0] wr_ptr_q, rd_ptr_q, fifo_count;
  logic        fifo_empty, fifo_full, tx_empty;
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [15:0] divisor_q;

  state_e      tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_pop, tx_bit_end;

  state_e      rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half_m1;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_bit_end;
  logic        rx_load, rx_ferr, rx_valid_q, overrun_q, frame_err_q;

  logic unused_ok;
  assign unused_ok = ^{dmem_write_mode, dmem_read_mode, dmem_address[31:4],
                       dmem_address[1:0], dmem_write_data[31:16]};

  assign sel        = dmem_address[3:2];
  assign wr_req     = dmem_enable & dmem_write_enable;
  assign rd_req     = dmem_enable & dmem_read_enable & ~dmem_write_enable;
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == DEPTH_P);
  assign dmem_wait  = wr_req & (sel == 2'd0) & fifo_full;
  assign push       = wr_req & (sel == 2'd0) & ~fifo_full;
  assign rx_pop     = rd_req & (sel == 2'd0);
  assign tx_empty   = fifo_empty & (tx_state_q == S_IDLE);

  always_comb begin
    dmem_read_data = '0;
    if (dmem_enable && dmem_read_enable) begin
      case (sel)
        2'd0:    dmem_read_data = {24'b0, rx_byte_q};
        2'd1:    dmem_read_data = {27'b0, frame_err_q, overrun_q, rx_valid_q, tx_empty, fifo_full};
        2'd2:    dmem_read_data = {16'b0, divisor_q};
        default: dmem_read_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= dmem_write_data[7:0];
  end

  // Transmitter: next frame is loaded straight from STOP so queued bytes leave with no idle gap.
  assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    if (tx_state_q != S_IDLE) tx_cnt_d = tx_bit_end ? 16'd0 : tx_cnt_q + 16'd1;
    case (tx_state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr_q[AW-1:0]];
          tx_div_d   = divisor_q;
          tx_cnt_d   = 16'd0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_bit_end) begin
          tx_idx_d   = 3'd0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_idx_d   = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'd7) tx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_bit_end) begin
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = fifo_mem[rd_ptr_q[AW-1:0]];
            tx_div_d   = divisor_q;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state_q)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = tx_shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  // Receiver: start bit confirmed at half a bit, then every sample lands at a bit centre.
  assign rx_half_m1 = {1'b0, rx_div_q[15:1]} - 16'd1;
  assign rx_bit_end = (rx_cnt_q == rx_div_q - 16'd1);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_div_d   = rx_div_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_load    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = 16'd0;
        if (rx_prev_q && !rx_s2_q) begin
          rx_div_d   = divisor_q;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == rx_half_m1) begin
          rx_cnt_d   = 16'd0;
          rx_idx_d   = 3'd0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = 16'd0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_idx_d   = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d   = 16'd0;
          rx_load    = rx_s2_q;
          rx_ferr    = ~rx_s2_q;
          rx_state_d = S_IDLE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      divisor_q   <= DEF_DIV;
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_div_q    <= DEF_DIV;
      tx_idx_q    <= '0;
      tx_shift_q  <= '0;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_div_q    <= DEF_DIV;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (tx_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_req && sel == 2'd2)
        divisor_q <= (dmem_write_data[15:0] < 16'd4) ? 16'd4 : dmem_write_data[15:0];
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      if (wr_req && sel == 2'd1 && dmem_write_data[3]) overrun_q   <= 1'b0;
      if (wr_req && sel == 2'd1 && dmem_write_data[4]) frame_err_q <= 1'b0;
      if (rx_ferr) frame_err_q <= 1'b1;
      if (rx_load) begin
        rx_byte_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
        if (rx_valid_q && !rx_pop) overrun_q <= 1'b1;
      end else if (rx_pop) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

endmodule
